// File: rtl/rnd_key_sched_ctrl.sv
// rnd_key_sched_ctrl
//   DES key-schedule controller. Takes a 64b key, runs PC1 / per-round left
//   rotation / PC2 and writes K1..K16 into an external 16x48 round-key
//   storage (addr 0..15). It then hands the Feistel datapath one round key
//   per valid/ready handshake, either in K1..K16 (encrypt) or K16..K1
//   (decrypt) order. It is the only master of the storage ports.
// Ports
//   clk, rst                     clock (rising edge), async active-low reset
//   key_valid/key_ready/key_in   64b key intake (parity bits ignored)
//   start/decrypt/start_ready    begin one 16-key service sequence
//   rk_valid/rk_ready/rk_out     round-key stream, rk_out = stor_dout
//   rk_round/rk_last             service-order index, last-key flag
//   done                         1-cycle pulse after the 16th handshake
//   key_loaded                   storage holds a complete schedule
//   stor_mode/addr/din/dout      storage port (mode 1 = write, 1-cycle read)
module rnd_key_sched_ctrl #(
  parameter int ROUNDS     = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int RK_WIDTH   = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  output logic                  key_ready,
  input  logic [63:0]           key_in,
  input  logic                  start,
  input  logic                  decrypt,
  output logic                  start_ready,
  output logic                  rk_valid,
  input  logic                  rk_ready,
  output logic [RK_WIDTH-1:0]   rk_out,
  output logic [ADDR_WIDTH-1:0] rk_round,
  output logic                  rk_last,
  output logic                  done,
  output logic                  key_loaded,
  output logic                  stor_mode,
  output logic [ADDR_WIDTH-1:0] stor_addr,
  output logic [RK_WIDTH-1:0]   stor_din,
  input  logic [RK_WIDTH-1:0]   stor_dout
);

  typedef enum logic [2:0] {IDLE, GEN, READY, FETCH, WAIT} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(ROUNDS - 1);
  // Rounds that rotate by two: i = 2..7 and 9..14.
  localparam logic [15:0] TWO_SHIFT = 16'h7EFC;

  // FIPS 46 tables, bit 1 = MSB.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int j = 0; j < 56; j++) r[55-j] = k[64-PC1[j]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int j = 0; j < 48; j++) r[47-j] = cd[56-PC2[j]];
    return r;
  endfunction

  // C = cd[55:28], D = cd[27:0]; each half rotates independently.
  function automatic logic [55:0] rotl(input logic [55:0] cd, input logic two);
    logic [27:0] c, d;
    c = cd[55:28];
    d = cd[27:0];
    if (two) begin
      c = {c[25:0], c[27:26]};
      d = {d[25:0], d[27:26]};
    end else begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    return {c, d};
  endfunction

  state_t                state;
  logic [55:0]           cd;
  logic [55:0]           cd_rot;
  logic [ADDR_WIDTH-1:0] cnt;   // i in GEN, n in FETCH/WAIT
  logic                  dec;

  assign cd_rot = rotl(cd, TWO_SHIFT[cnt]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cd         <= '0;
      cnt        <= '0;
      dec        <= 1'b0;
      key_loaded <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (key_valid) begin
          cd    <= pc1(key_in);
          cnt   <= '0;
          state <= GEN;
        end
        GEN: begin
          cd <= cd_rot;
          if (cnt == LAST) begin
            cnt        <= '0;
            key_loaded <= 1'b1;
            state      <= READY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        READY: begin
          // A new key takes priority; a coincident start is dropped.
          if (key_valid) begin
            cd         <= pc1(key_in);
            cnt        <= '0;
            key_loaded <= 1'b0;
            state      <= GEN;
          end else if (start) begin
            dec   <= decrypt;
            cnt   <= '0;
            state <= FETCH;
          end
        end
        FETCH: state <= WAIT;
        WAIT: if (rk_ready) begin
          if (cnt == LAST) begin
            done  <= 1'b1;
            state <= READY;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode only registered state, so they are glitch-free.
  // The address is held through WAIT so the storage keeps re-reading the
  // same word and rk_out stays stable under backpressure.
  always_comb begin
    key_ready   = (state == IDLE) || (state == READY);
    start_ready = (state == READY);
    stor_mode   = (state == GEN);
    stor_din    = '0;
    stor_addr   = '0;
    if (state == GEN) begin
      stor_addr = cnt;
      stor_din  = pc2(cd_rot);
    end else if (state == FETCH || state == WAIT) begin
      stor_addr = dec ? (LAST - cnt) : cnt;
    end
    rk_valid = (state == WAIT);
    rk_round = (state == WAIT) ? cnt : '0;
    rk_last  = (state == WAIT) && (cnt == LAST);
  end

  assign rk_out = stor_dout;

endmodule

// File: tb/tb_rnd_key_sched_ctrl.sv
// tb_rnd_key_sched_ctrl
//   Directed bench: DUT plus a behavioural 16x48 storage with 1-cycle
//   registered read. Expected round keys are the FIPS 46 worked example for
//   key 133457799BBCDFF1.
module tb_rnd_key_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic [63:0] key_in = '0;
  logic        start = 1'b0;
  logic        decrypt = 1'b0;
  logic        start_ready;
  logic        rk_valid;
  logic        rk_ready = 1'b1;
  logic [47:0] rk_out;
  logic [3:0]  rk_round;
  logic        rk_last;
  logic        done;
  logic        key_loaded;
  logic        stor_mode;
  logic [3:0]  stor_addr;
  logic [47:0] stor_din;
  logic [47:0] stor_dout = '0;

  logic [47:0] mem [16];

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [47:0] KS [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

  rnd_key_sched_ctrl dut (
    .clk(clk), .rst(rst),
    .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
    .start(start), .decrypt(decrypt), .start_ready(start_ready),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_out(rk_out),
    .rk_round(rk_round), .rk_last(rk_last), .done(done),
    .key_loaded(key_loaded),
    .stor_mode(stor_mode), .stor_addr(stor_addr),
    .stor_din(stor_din), .stor_dout(stor_dout));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (stor_mode) mem[stor_addr] <= stor_din;
    else           stor_dout      <= mem[stor_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered one cycle after the key was accepted (GEN, i=0). Start is held
  // high for the first half to show it is ignored during generation.
  task automatic gen_check();
    for (int k = 0; k < 16; k++) begin
      chk("gen_mode", stor_mode, 1);
      chk("gen_addr", stor_addr, k);
      chk("gen_din", stor_din, KS[k]);
      chk("gen_kready", key_ready, 0);
      chk("gen_sready", start_ready, 0);
      chk("gen_loaded", key_loaded, 0);
      start = (k < 8);
      step();
    end
    start = 1'b0;
    chk("rdy_loaded", key_loaded, 1);
    chk("rdy_kready", key_ready, 1);
    chk("rdy_sready", start_ready, 1);
    chk("rdy_mode", stor_mode, 0);
    chk("mem0", mem[0], KS[0]);
    chk("mem15", mem[15], KS[15]);
  endtask

  task automatic load_key();
    key_valid = 1'b1;
    key_in    = KEY;
    step();
    key_valid = 1'b0;
    key_in    = '0;
  endtask

  // stall_at: service index held off for 5 cycles (-1 = none)
  // abort_at: service index at which reset is pulsed (-1 = none)
  task automatic serve(input bit dec, input int stall_at, input int abort_at);
    int r, cyc, idx;
    start   = 1'b1;
    decrypt = dec;
    rk_ready = 1'b1;
    step();
    start   = 1'b0;
    decrypt = ~dec;
    r   = 0;
    cyc = 0;
    while (r < 16 && cyc < 200) begin
      if (rk_valid) begin
        idx = dec ? 15 - r : r;
        chk("rk_out", rk_out, KS[idx]);
        chk("rk_round", rk_round, r);
        chk("rk_last", rk_last, r == 15);
        chk("srv_addr", stor_addr, idx);
        chk("srv_mode", stor_mode, 0);
        if (r == abort_at) begin
          rst = 1'b0;
          #1;
          chk("abort_kready", key_ready, 1);
          chk("abort_valid", rk_valid, 0);
          chk("abort_loaded", key_loaded, 0);
          chk("abort_done", done, 0);
          step();
          rst = 1'b1;
          for (int k = 0; k < 3; k++) begin
            step();
            chk("abort_nodone", done, 0);
            chk("abort_idle", start_ready, 0);
          end
          return;
        end
        if (r == stall_at) begin
          rk_ready  = 1'b0;
          key_valid = 1'b1;
          key_in    = ~KEY;
          start     = 1'b1;
          for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_valid", rk_valid, 1);
            chk("stall_out", rk_out, KS[idx]);
            chk("stall_round", rk_round, r);
            chk("stall_addr", stor_addr, idx);
            chk("stall_kready", key_ready, 0);
            chk("stall_sready", start_ready, 0);
          end
          key_valid = 1'b0;
          key_in    = '0;
          start     = 1'b0;
          rk_ready  = 1'b1;
        end
        r++;
      end else begin
        chk("fetch_done", done, 0);
      end
      step();
      cyc++;
    end
    chk("srv_count", r, 16);
    chk("srv_cycles", cyc, 32);
    chk("done_pulse", done, 1);
    chk("done_sready", start_ready, 1);
    step();
    chk("done_clear", done, 0);
    chk("still_loaded", key_loaded, 1);
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_kready", key_ready, 1);
    chk("rst_valid", rk_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_loaded", key_loaded, 0);
    chk("rst_mode", stor_mode, 0);
    step();
    rst = 1'b1;

    // start in IDLE is ignored
    start = 1'b1;
    step();
    start = 1'b0;
    chk("idle_kready", key_ready, 1);
    chk("idle_sready", start_ready, 0);
    chk("idle_mode", stor_mode, 0);

    load_key();
    gen_check();

    serve(1'b0, -1, -1);
    serve(1'b1, 3, -1);
    serve(1'b0, 3, -1);

    // Simultaneous key_valid + start in READY: reload wins
    key_valid = 1'b1;
    key_in    = KEY;
    start     = 1'b1;
    decrypt   = 1'b0;
    step();
    key_valid = 1'b0;
    start     = 1'b0;
    chk("both_gen", stor_mode, 1);
    chk("both_valid", rk_valid, 0);
    chk("both_loaded", key_loaded, 0);
    chk("both_sready", start_ready, 0);
    gen_check();

    // Reset in the middle of generation (i=7)
    load_key();
    for (int k = 0; k < 7; k++) step();
    chk("g7_addr", stor_addr, 7);
    rst = 1'b0;
    #1;
    chk("g7_mode", stor_mode, 0);
    chk("g7_kready", key_ready, 1);
    chk("g7_loaded", key_loaded, 0);
    step();
    rst = 1'b1;
    step();
    chk("g7_idle", start_ready, 0);
    chk("g7_mode2", stor_mode, 0);

    load_key();
    gen_check();

    // Reset during service at n=9, then regenerate and serve again
    serve(1'b0, -1, 9);
    load_key();
    gen_check();
    serve(1'b1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
